// File: rtl/warp_done_tracker.sv
// warp_done_tracker: loads a block's unused-warp mask, records warp completions, raises block_done until acked
module warp_done_tracker #(
    parameter int NUM_WARPS = 32,
    parameter int WARP_ID_W = 5,
    parameter int CNT_W     = 6
) (
    input  logic                 clk_in,
    input  logic                 host_reset_n,
    input  logic                 start,
    input  logic [NUM_WARPS-1:0] warps_done_mask_in,
    input  logic                 warp_done_valid,
    input  logic [WARP_ID_W-1:0] warp_done_id,
    output logic                 warp_done_ready,
    output logic                 block_done,
    input  logic                 block_done_ack,
    output logic                 busy,
    output logic [NUM_WARPS-1:0] done_mask,
    output logic [CNT_W-1:0]     pending_cnt,
    output logic                 dup_err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [NUM_WARPS-1:0] mask_nxt;
    logic [CNT_W-1:0] cnt_nxt, zeros;
    logic err_nxt, hit;
    always_ff @(posedge clk_in) begin
        if (!host_reset_n) begin
            state       <= IDLE;
            done_mask   <= '0;
            pending_cnt <= '0;
            dup_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            done_mask   <= mask_nxt;
            pending_cnt <= cnt_nxt;
            dup_err     <= err_nxt;
        end
    end
    always_comb begin
        zeros = '0;
        for (int i = 0; i < NUM_WARPS; i++) zeros = zeros + CNT_W'(!warps_done_mask_in[i]);
        hit       = done_mask[warp_done_id];
        state_nxt = state;
        mask_nxt  = done_mask;
        cnt_nxt   = pending_cnt;
        err_nxt   = dup_err;
        case (state)
            IDLE: if (start) begin
                mask_nxt  = warps_done_mask_in;
                cnt_nxt   = zeros;
                err_nxt   = 1'b0;
                state_nxt = &warps_done_mask_in ? DONE : RUN;
            end
            RUN: if (warp_done_valid) begin
                // only a 0->1 transition touches the count, so it cannot underflow
                if (hit) err_nxt = 1'b1;
                else begin
                    mask_nxt  = done_mask | (NUM_WARPS'(1) << warp_done_id);
                    cnt_nxt   = pending_cnt - CNT_W'(1);
                    state_nxt = (pending_cnt == CNT_W'(1)) ? DONE : RUN;
                end
            end
            DONE: if (block_done_ack) begin
                state_nxt = IDLE;
                mask_nxt  = '0;
                cnt_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign warp_done_ready = (state == RUN);
    assign block_done      = (state == DONE);
    assign busy            = (state != IDLE);
endmodule
